// File: rtl/uart_pkg.sv
// Shared UART receive-path types.
//   rx_err_t        : per-frame receiver error flags, packed {brk, stop, parity}
//   rx_ctrl_state_t : one-hot receive controller state
//   ERR_W           : width of rx_err_t
package uart_pkg;

  localparam int ERR_W = 3;

  typedef struct packed {
    logic brk;
    logic stop;
    logic parity;
  } rx_err_t;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'b001,
    ST_ARMED    = 3'b010,
    ST_HOLD     = 3'b100
  } rx_ctrl_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO for received frames.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : write request and entry
//   pop          : read request (ignored when empty)
//   flush        : empties the FIFO, overrides push/pop
//   dout         : head entry (zero while empty)
//   level        : entries held; empty/full derived from it
//   level_nxt    : level after the current edge
//   dout_nxt     : head entry after the current edge (zero if it will be empty)
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level_nxt,
  output logic [WIDTH-1:0]         dout_nxt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic             pop_ok, push_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop & ~empty & ~flush;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok) & ~flush;

  assign rd_ptr_nxt = rd_ptr + AW'(pop_ok);
  assign level_nxt  = flush ? '0 : level + LW'(push_ok) - LW'(pop_ok);

  assign dout = empty ? '0 : mem[rd_ptr];

  // Next head: the slot being written this cycle is the head only when the
  // FIFO is (or becomes) a single entry, so forward din in that case.
  always_comb begin
    dout_nxt = '0;
    if (level_nxt != '0) begin
      if (push_ok && (wr_ptr == rd_ptr_nxt))
        dout_nxt = din;
      else
        dout_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
    end
  end

  // Storage carries data only; it is never read while empty.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: arms the receiver, buffers completed frames with
// their error flags, throttles the receiver when the buffer is full and
// raises a level interrupt.
//   clk, reset_n   : clock, asynchronous active-low reset
//   enable         : host receive enable
//   clear          : flush FIFO, clear sticky flags and timeout counter
//   rx_start_n     : receiver arm (0 = armed), registered
//   rx_done/rx_data/parity_error/stop_error/break_error : receiver frame
//   rd_en          : host pop
//   rd_data/rd_err : FIFO head (show-ahead), rd_err = {break, stop, parity}
//   level/empty/full : FIFO status
//   overrun/timeout  : sticky flags
//   irq            : registered level interrupt
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_SIZE      = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int RX_THRESHOLD   = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        clear,
  output logic                        rx_start_n,
  input  logic                        rx_done,
  input  logic [DATA_SIZE-1:0]        rx_data,
  input  logic                        parity_error,
  input  logic                        stop_error,
  input  logic                        break_error,
  input  logic                        rd_en,
  output logic [DATA_SIZE-1:0]        rd_data,
  output logic [ERR_W-1:0]            rd_err,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        empty,
  output logic                        full,
  output logic                        overrun,
  output logic                        timeout,
  output logic                        irq
);

  localparam int EW = DATA_SIZE + ERR_W;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  rx_ctrl_state_t state;
  rx_err_t        wr_err;
  logic [EW-1:0]  wr_entry, head, head_nxt;
  logic [LW-1:0]  level_nxt;
  logic           full_nxt, pop_ok, drop;
  logic           overrun_nxt, timeout_nxt, irq_nxt;
  logic [CW-1:0]  to_cnt, to_cnt_nxt;

  assign wr_err   = {break_error, stop_error, parity_error};
  assign wr_entry = {wr_err, rx_data};

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rx_done & ~clear),
    .pop       (rd_en),
    .flush     (clear),
    .din       (wr_entry),
    .dout      (head),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .level_nxt (level_nxt),
    .dout_nxt  (head_nxt)
  );

  assign rd_data  = head[DATA_SIZE-1:0];
  assign rd_err   = head[DATA_SIZE +: ERR_W];
  assign full_nxt = (level_nxt == LW'(FIFO_DEPTH));
  assign pop_ok   = rd_en & ~empty;
  // Frame lost only when full and the head is not leaving this cycle.
  assign drop     = rx_done & ~clear & full & ~pop_ok;

  // Idle counter runs only while frames wait unread.
  always_comb begin
    to_cnt_nxt = to_cnt;
    if (clear || rx_done || rd_en || empty)
      to_cnt_nxt = '0;
    else if (to_cnt != CW'(TIMEOUT_CYCLES))
      to_cnt_nxt = to_cnt + CW'(1);
  end

  assign overrun_nxt = ~clear & (overrun | drop);
  assign timeout_nxt = ~clear & ~pop_ok &
                       (timeout | (to_cnt_nxt == CW'(TIMEOUT_CYCLES)));

  // irq is registered from next-state values so it rises together with the
  // status it reflects.
  assign irq_nxt = (level_nxt >= LW'(RX_THRESHOLD)) | timeout_nxt | overrun_nxt |
                   ((level_nxt != '0) & (|head_nxt[DATA_SIZE +: ERR_W]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt  <= '0;
      overrun <= 1'b0;
      timeout <= 1'b0;
      irq     <= 1'b0;
    end else begin
      to_cnt  <= to_cnt_nxt;
      overrun <= overrun_nxt;
      timeout <= timeout_nxt;
      irq     <= irq_nxt;
    end
  end

  // Receiver arm FSM; full_nxt lets a write that fills the FIFO hold the
  // receiver at the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_DISABLED;
      rx_start_n <= 1'b1;
    end else begin
      case (state)
        ST_DISABLED: begin
          if (enable) begin
            if (full_nxt) begin
              state      <= ST_HOLD;
              rx_start_n <= 1'b1;
            end else begin
              state      <= ST_ARMED;
              rx_start_n <= 1'b0;
            end
          end
        end
        ST_ARMED: begin
          if (!enable) begin
            state      <= ST_DISABLED;
            rx_start_n <= 1'b1;
          end else if (full_nxt) begin
            state      <= ST_HOLD;
            rx_start_n <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (!enable) begin
            state      <= ST_DISABLED;
            rx_start_n <= 1'b1;
          end else if (!full_nxt) begin
            state      <= ST_ARMED;
            rx_start_n <= 1'b0;
          end
        end
        default: begin
          state      <= ST_DISABLED;
          rx_start_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

  localparam int DS = 8;
  localparam int FD = 16;
  localparam int TH = 8;
  localparam int TO = 32;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic          clear;
  logic          rx_start_n;
  logic          rx_done;
  logic [DS-1:0] rx_data;
  logic          parity_error;
  logic          stop_error;
  logic          break_error;
  logic          rd_en;
  logic [DS-1:0] rd_data;
  logic [2:0]    rd_err;
  logic [4:0]    level;
  logic          empty;
  logic          full;
  logic          overrun;
  logic          timeout;
  logic          irq;

  int n_chk;
  int n_pass;

  uart_rx_ctrl #(
    .DATA_SIZE      (DS),
    .FIFO_DEPTH     (FD),
    .RX_THRESHOLD   (TH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .clear        (clear),
    .rx_start_n   (rx_start_n),
    .rx_done      (rx_done),
    .rx_data      (rx_data),
    .parity_error (parity_error),
    .stop_error   (stop_error),
    .break_error  (break_error),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_err       (rd_err),
    .level        (level),
    .empty        (empty),
    .full         (full),
    .overrun      (overrun),
    .timeout      (timeout),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] e);
    rx_data = d;
    {break_error, stop_error, parity_error} = e;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    {break_error, stop_error, parity_error} = 3'b000;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_start_n"}, rx_start_n, 1);
    check({pfx, "_level"},   level,      0);
    check({pfx, "_empty"},   empty,      1);
    check({pfx, "_full"},    full,       0);
    check({pfx, "_overrun"}, overrun,    0);
    check({pfx, "_timeout"}, timeout,    0);
    check({pfx, "_irq"},     irq,        0);
    check({pfx, "_rd_data"}, rd_data,    0);
    check({pfx, "_rd_err"},  rd_err,     0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset_n = 1'b0;
    enable = 1'b0;
    clear = 1'b0;
    rx_done = 1'b0;
    rx_data = '0;
    parity_error = 1'b0;
    stop_error = 1'b0;
    break_error = 1'b0;
    rd_en = 1'b0;
    repeat (2) tick();
    check_reset_vals("rst");

    reset_n = 1'b1;
    tick();
    check("dis_start_n", rx_start_n, 1);
    enable = 1'b1;
    tick();
    check("arm_start_n", rx_start_n, 0);

    // Three frames then three pops
    send(8'h41, 3'b000);
    send(8'h42, 3'b000);
    send(8'h43, 3'b000);
    check("three_level", level, 3);
    check("three_head", rd_data, 8'h41);
    check("three_irq", irq, 0);
    check("pop0", rd_data, 8'h41); pop_one();
    check("pop1", rd_data, 8'h42); pop_one();
    check("pop2", rd_data, 8'h43); pop_one();
    check("drain_empty", empty, 1);
    check("drain_level", level, 0);

    // Fill to full, then overrun
    for (int i = 0; i < 16; i++) send(8'(i), 3'b000);
    check("fill_full", full, 1);
    check("fill_level", level, 16);
    check("fill_hold", rx_start_n, 1);
    check("fill_irq", irq, 1);
    check("fill_overrun", overrun, 0);
    send(8'hAA, 3'b000);
    check("ovr_flag", overrun, 1);
    check("ovr_level", level, 16);
    check("ovr_irq", irq, 1);
    check("ovr_head", rd_data, 0);
    pop_one();
    check("hold_pop_level", level, 15);
    check("hold_pop_arm", rx_start_n, 0);
    check("hold_pop_head", rd_data, 1);
    check("ovr_sticky", overrun, 1);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr1_level", level, 0);
    check("clr1_overrun", overrun, 0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 3'b000);
    check("full2", full, 1);
    rd_en = 1'b1;
    rx_data = 8'hEE;
    rx_done = 1'b1;
    tick();
    rd_en = 1'b0;
    rx_done = 1'b0;
    check("simul_level", level, 16);
    check("simul_overrun", overrun, 0);
    check("simul_head", rd_data, 8'h11);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("simul_pop%0d", i), rd_data, 8'h10 + i);
      pop_one();
    end
    check("simul_tail", rd_data, 8'hEE);
    pop_one();
    check("simul_empty", empty, 1);

    // Error flags
    send(8'h55, 3'b001);
    check("par_data", rd_data, 8'h55);
    check("par_err", rd_err, 3'b001);
    check("par_irq", irq, 1);
    pop_one();
    check("par_irq_off", irq, 0);
    send(8'h00, 3'b100);
    check("brk_err", rd_err, 3'b100);
    check("brk_irq", irq, 1);
    pop_one();
    check("brk_rd_err_empty", rd_err, 0);

    // Character timeout
    send(8'h33, 3'b000);
    repeat (31) tick();
    check("to_before", timeout, 0);
    check("to_before_irq", irq, 0);
    tick();
    check("to_hit", timeout, 1);
    check("to_irq", irq, 1);
    pop_one();
    check("to_pop_clear", timeout, 0);
    check("to_pop_irq", irq, 0);

    // Clear with simultaneous rx_done
    for (int i = 0; i < 17; i++) send(8'(8'h60 + i), 3'b000);
    check("pre_clr_overrun", overrun, 1);
    clear = 1'b1;
    rx_data = 8'h99;
    rx_done = 1'b1;
    tick();
    clear = 1'b0;
    rx_done = 1'b0;
    check("clr_level", level, 0);
    check("clr_empty", empty, 1);
    check("clr_full", full, 0);
    check("clr_overrun", overrun, 0);
    check("clr_timeout", timeout, 0);
    check("clr_irq", irq, 0);
    tick();
    check("clr_discard", empty, 1);

    // Asynchronous reset mid-stream
    send(8'h01, 3'b000);
    send(8'h02, 3'b010);
    check("pre_rst_level", level, 2);
    rx_data = 8'h03;
    rx_done = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("arst");
    rx_done = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver. It arms the receiver via its active-low start input and captures each completed frame with its error flags into a show-ahead FIFO. It throttles the receiver when the FIFO is full and raises a level interrupt on threshold, character timeout or error. It sits between the receiver and the host/register interface.

## Interface
- DATA_SIZE, 8, frame data width (matches receiver)
- FIFO_DEPTH, 16, entries; power of two, >= 2
- RX_THRESHOLD, 8, interrupt level, 1..FIFO_DEPTH
- TIMEOUT_CYCLES, 4096, idle clocks with FIFO non-empty before timeout, >= 1

- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  host receive enable
- clear  in  1  one-cycle pulse: flush FIFO, clear sticky flags
- rx_start_n  out  1  to receiver; 0 = armed
- rx_done  in  1  receiver frame-complete strobe (one cycle)
- rx_data  in  DATA_SIZE  receiver data, valid with rx_done
- parity_error, stop_error, break_error  in  1 each  receiver flags, valid with rx_done
- rd_en  in  1  host pop
- rd_data  out  DATA_SIZE  FIFO head data (show-ahead)
- rd_err  out  3  head flags {break, stop, parity}
- level  out  $clog2(FIFO_DEPTH)+1  entries held
- empty, full  out  1 each  FIFO status
- overrun  out  1  sticky: frame dropped because FIFO full
- timeout  out  1  sticky: character timeout
- irq  out  1  level interrupt

## Operation
- FSM states (one-hot): DISABLED, ARMED, HOLD.
  - DISABLED: rx_start_n=1. enable=1 -> ARMED (HOLD if full).
  - ARMED: rx_start_n=0. enable=0 -> DISABLED; full (or write making it full this cycle) -> HOLD.
  - HOLD: rx_start_n=1. enable=0 -> DISABLED; level < FIFO_DEPTH after a pop -> ARMED.
- Frame capture: on rx_done, write {break,stop,parity,rx_data} if not full after accounting for same-cycle pop. Frames completing in any state are written if space; receiver finishes an in-progress frame regardless of rx_start_n.
- rx_done while full with no pop: frame dropped, overrun set.
- Pop: rd_en with !empty advances head. rd_en on empty ignored, no flag change.
- Simultaneous rd_en and rx_done: pop and push both occur; level unchanged; when full, write accepted.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1). Cleared on rx_done, rd_en or while empty. Otherwise increments, saturating at TIMEOUT_CYCLES. Reaching TIMEOUT_CYCLES sets timeout.
- timeout clears on pop or clear. overrun clears on clear only.
- irq = (level >= RX_THRESHOLD) | timeout | overrun | (!empty & |rd_err).
- clear: level -> 0, pointers -> 0, overrun/timeout -> 0, counter -> 0. An rx_done in the same cycle is discarded. FSM state is unaffected.

## Timing
- Reset: rx_start_n=1, state DISABLED, level=0, empty=1, full=0, overrun=0, timeout=0, irq=0, rd_data=0, rd_err=0.
- rx_done at edge N: level/empty/full/rd_data update after edge N (visible cycle N+1).
- rx_start_n is registered from the FSM. It changes one cycle after the causing enable/full/pop.
- rd_data/rd_err are valid combinationally whenever empty=0. The next entry appears the cycle after the rd_en edge.
- irq is registered: one cycle after its causing condition.
- Pointers wrap modulo FIFO_DEPTH. level distinguishes full from empty.
- Reset mid-frame: all state is lost immediately. The receiver is reset by the same reset_n.

## Structure
- Shared package uart_pkg:
  - typedef rx_err_t (packed struct break/stop/parity)
  - typedef rx_ctrl_state_t (one-hot enum)
  - ERR_W = 3 constant
- Sub-module uart_rx_fifo: parameterised synchronous show-ahead FIFO (DATA_SIZE+3 wide, FIFO_DEPTH deep), with push, pop, flush, level, empty and full.
- FSM, timeout counter, sticky flags and irq live in uart_rx_ctrl.

## Test plan
- Reset, enable=1 -> rx_start_n 0 after one cycle; three rx_done frames 0x41/0x42/0x43 -> level=3, rd_data=0x41, three pops return 0x41,0x42,0x43, empty=1.
- FIFO_DEPTH=16, 16 frames, no pops -> full=1, rx_start_n=1 (HOLD). 17th rx_done -> overrun=1, irq=1, level=16. One pop -> ARMED, rx_start_n=0 next cycle.
- Full FIFO, rx_done and rd_en same cycle -> level stays 16, new data at tail, overrun stays 0.
- rx_done with parity_error=1, data 0x55 -> rd_err=3'b001, irq=1. break frame data 0x00 -> rd_err=3'b100.
- TIMEOUT_CYCLES=32, one frame then idle -> timeout=1 and irq=1 exactly 32 cycles after rx_done. Pop -> timeout=0.
- Mid-fill clear with simultaneous rx_done -> level=0, empty=1, flags cleared, frame discarded. reset_n low mid-stream -> all outputs return to reset values.
